vec_requant_writeback: RTL and testbench

- Sits directly downstream of the column-reduction/accumulator stage and consumes its TILE_SIZE-wide ACC_WIDTH result vectors.
- Selected vectors are buffered in a small FIFO, requantized (rounding arithmetic right shift plus saturation to OUT_WIDTH), and serialized one element per beat over a valid/ready stream to the writeback/memory path.
- The upstream stage has no backpressure, so this block absorbs bursts and flags any loss.

---
 rtl/vec_requant_writeback_if.sv | 29 ++
 rtl/vec_requant_writeback.sv | 230 +++++++++++++++++++++++
 tb/tb_vec_requant_writeback.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_requant_writeback_if.sv
// Output element stream of vec_requant_writeback: one requantized element per
// beat with valid/ready handshake plus last-of-vector and saturation tags.
interface vec_requant_writeback_if #(
  parameter int OUT_WIDTH = 8
) ();
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_last;
  logic                        out_sat;

  // Producer side (the requantizer drives the element, sink drives ready)
  modport master (
    output out_valid,
    output out_data,
    output out_last,
    output out_sat,
    input  out_ready
  );

  // Consumer side (writeback / memory path)
  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_sat,
    output out_ready
  );
endinterface

// File: rtl/vec_requant_writeback.sv
// Buffers committed accumulator vectors in a small FIFO, requantizes a whole
// vector at pop time (rounding arithmetic right shift + saturation) into a
// hold array, then serializes it one element per beat. The upstream producer
// cannot be stalled, so a committed vector that finds the FIFO full is
// dropped and recorded in a sticky overflow flag.
module vec_requant_writeback #(
  parameter int TILE_SIZE  = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT_W    = $clog2(ACC_WIDTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                valid_in,
  input  logic                                commit,
  input  logic [TILE_SIZE-1:0][ACC_WIDTH-1:0] vec_in,
  input  logic [SHIFT_W-1:0]                  shift_amt,
  input  logic                                clear_err,
  vec_requant_writeback_if.master             out_if,
  output logic                                overflow,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TILE_SIZE - 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  // Saturation bounds and rounding unit, held one bit wider than the input
  // so that adding the rounding constant can never wrap.
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [ACC_WIDTH:0] RND_ONE = (ACC_WIDTH+1)'(1);

  typedef logic [TILE_SIZE-1:0][ACC_WIDTH-1:0] vec_t;
  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Round-half-up arithmetic shift then clamp; result is {sat, data}.
  function automatic logic [OUT_WIDTH:0] requant(
    input logic [ACC_WIDTH-1:0] x,
    input logic [SHIFT_W-1:0]   sh
  );
    logic signed [ACC_WIDTH:0] ext_v;
    logic signed [ACC_WIDTH:0] rnd_v;
    logic signed [ACC_WIDTH:0] r_v;
    logic [OUT_WIDTH:0]        res_v;
    ext_v = $signed({x[ACC_WIDTH-1], x});
    if (sh != {SHIFT_W{1'b0}}) begin
      rnd_v = RND_ONE << (sh - 1'b1);
    end else begin
      rnd_v = '0;
    end
    r_v = (ext_v + rnd_v) >>> sh;
    if (r_v > SAT_MAX) begin
      res_v = {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    end else if (r_v < SAT_MIN) begin
      res_v = {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    end else begin
      res_v = {1'b0, r_v[OUT_WIDTH-1:0]};
    end
    return res_v;
  endfunction

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   ovf_q, ovf_d;
  vec_t                   mem_q [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0]   hold_data_q [TILE_SIZE];
  logic [OUT_WIDTH-1:0]   hold_data_d [TILE_SIZE];
  logic [TILE_SIZE-1:0]   hold_sat_q, hold_sat_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   out_sat_q, out_sat_d;

  logic                   push_req_s, push_ok_s, drop_s;
  logic                   pop_s, load_s, empty_s, full_s;
  logic [IDX_W-1:0]       idx_inc_s;
  vec_t                   head_s;

  assign empty_s    = (level_q == {LVL_W{1'b0}});
  assign full_s     = (level_q == DEPTH_LVL);
  assign push_req_s = valid_in & commit;
  // A full FIFO still accepts when the head leaves at the same edge.
  assign push_ok_s  = push_req_s & (~full_s | pop_s);
  assign drop_s     = push_req_s & ~push_ok_s;
  assign head_s     = mem_q[rd_ptr_q];
  assign idx_inc_s  = idx_q + 1'b1;

  // Occupancy and sticky loss flag next-state (a drop wins over a clear)
  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q;
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clear_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Serializer FSM: pop/requantize, walk the hold array, chain vectors without a bubble
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_data_d = hold_data_q;
    hold_sat_d  = hold_sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          load_s  = 1'b1;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (out_if.out_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d      = idx_inc_s;
            out_data_d = hold_data_q[idx_inc_s];
            out_sat_d  = hold_sat_q[idx_inc_s];
            out_last_d = (idx_inc_s == LAST_IDX);
          end else if (!empty_s) begin
            load_s = 1'b1;
          end else begin
            state_d     = IDLE;
            idx_d       = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
            out_sat_d   = 1'b0;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d     = IDLE;
        idx_d       = '0;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_last_d  = 1'b0;
        out_sat_d   = 1'b0;
      end
    endcase
    if (load_s) begin
      pop_s = 1'b1;
      for (int i = 0; i < TILE_SIZE; i++) begin
        {hold_sat_d[i], hold_data_d[i]} = requant(head_s[i], shift_amt);
      end
      idx_d       = '0;
      out_valid_d = 1'b1;
      out_data_d  = hold_data_d[0];
      out_sat_d   = hold_sat_d[0];
      out_last_d  = (LAST_IDX == {IDX_W{1'b0}});
    end else begin
      pop_s = 1'b0;
    end
  end

  // Control, pointer, hold and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      hold_sat_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < TILE_SIZE; i++) begin
        hold_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      hold_data_q <= hold_data_d;
      hold_sat_q  <= hold_sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Vector storage; contents are qualified by level so they need no reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= vec_in;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_last  = out_last_q;
  assign out_if.out_sat   = out_sat_q;
  assign overflow         = ovf_q;
  assign fifo_level       = level_q;

endmodule

// File: tb/tb_vec_requant_writeback.sv
// Directed bench for vec_requant_writeback (FIFO_DEPTH=2 so the overflow
// corner is reachable with a handful of vectors). Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_vec_requant_writeback;

  typedef logic [3:0][31:0] vec_t;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic       commit;
  vec_t       vec_in;
  logic [4:0] shift_amt;
  logic       clear_err;
  logic       overflow;
  logic [1:0] fifo_level;
  int         checks;
  int         errors;

  vec_requant_writeback_if #(.OUT_WIDTH(8)) oif ();

  vec_requant_writeback #(
    .TILE_SIZE (4),
    .ACC_WIDTH (32),
    .OUT_WIDTH (8),
    .FIFO_DEPTH(2),
    .SHIFT_W   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .commit    (commit),
    .vec_in    (vec_in),
    .shift_amt (shift_amt),
    .clear_err (clear_err),
    .out_if    (oif.master),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkvec(input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v[0] = e0;
    v[1] = e1;
    v[2] = e2;
    v[3] = e3;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check the element on the bus, then let it handshake (out_ready must be 1)
  task automatic expect_elem(input string tag, input int d, input int l, input int s);
    chk({tag, ".valid"}, oif.out_valid, 1);
    chk({tag, ".data"}, oif.out_data, d);
    chk({tag, ".last"}, oif.out_last, l);
    chk({tag, ".sat"}, oif.out_sat, s);
    tick();
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".valid"}, oif.out_valid, 0);
    chk({tag, ".level"}, fifo_level, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    valid_in = 1'b0;
    commit = 1'b0;
    vec_in = mkvec(0, 0, 0, 0);
    shift_amt = 5'd0;
    clear_err = 1'b0;
    oif.out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst.valid", oif.out_valid, 0);
    chk("rst.data", oif.out_data, 0);
    chk("rst.last", oif.out_last, 0);
    chk("rst.sat", oif.out_sat, 0);
    chk("rst.ovf", overflow, 0);
    chk("rst.level", fifo_level, 0);
    rst_n = 1'b1;
    tick();

    // Basic vector, shift 2: 100->25, -100->-25 (exact quarter), 255->64, -3->-1
    vec_in = mkvec(100, -100, 255, -3);
    shift_amt = 5'd2;
    valid_in = 1'b1;
    commit = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("t1.lat.valid", oif.out_valid, 0);
    chk("t1.lat.level", fifo_level, 1);
    tick();
    expect_elem("t1.e0", 25, 0, 0);
    expect_elem("t1.e1", -25, 0, 0);
    expect_elem("t1.e2", 64, 0, 0);
    expect_elem("t1.e3", -1, 1, 0);
    expect_idle("t1.end");

    // Shift 0 saturation vector, immediately followed by a half-way rounding vector
    vec_in = mkvec(1000, -1000, 127, -128);
    shift_amt = 5'd0;
    valid_in = 1'b1;
    tick();
    chk("t2.cap.level", fifo_level, 1);
    chk("t2.cap.valid", oif.out_valid, 0);
    vec_in = mkvec(-98, 2, -2, 6);
    tick();
    valid_in = 1'b0;
    chk("t2.pushpop.level", fifo_level, 1);
    shift_amt = 5'd2;
    expect_elem("t2.e0", 127, 0, 1);
    expect_elem("t2.e1", -128, 0, 1);
    expect_elem("t2.e2", 127, 0, 0);
    expect_elem("t2.e3", -128, 1, 0);
    // -98->-24, 2->1 (0.5 up), -2->0 (-0.5 up), 6->2 (1.5 up)
    expect_elem("t3.e0", -24, 0, 0);
    expect_elem("t3.e1", 1, 0, 0);
    expect_elem("t3.e2", 0, 0, 0);
    expect_elem("t3.e3", 2, 1, 0);
    expect_idle("t3.end");

    // Backpressure for 3 cycles while element 1 is on the bus
    vec_in = mkvec(100, -100, 255, -3);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    expect_elem("bp.e0", 25, 0, 0);
    oif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp.stall.valid", oif.out_valid, 1);
      chk("bp.stall.data", oif.out_data, -25);
      chk("bp.stall.last", oif.out_last, 0);
      tick();
    end
    oif.out_ready = 1'b1;
    expect_elem("bp.e1", -25, 0, 0);
    expect_elem("bp.e2", 64, 0, 0);
    expect_elem("bp.e3", -1, 1, 0);
    expect_idle("bp.end");

    // Overflow: out_ready low, four committed vectors on consecutive edges
    shift_amt = 5'd0;
    oif.out_ready = 1'b0;
    valid_in = 1'b1;
    vec_in = mkvec(1, 2, 3, 4);
    tick();
    chk("ov.v1.level", fifo_level, 1);
    chk("ov.v1.ovf", overflow, 0);
    vec_in = mkvec(5, 6, 7, 8);
    tick();
    chk("ov.v2.level", fifo_level, 1);
    chk("ov.v2.data", oif.out_data, 1);
    vec_in = mkvec(9, 10, 11, 12);
    tick();
    chk("ov.v3.level", fifo_level, 2);
    chk("ov.v3.ovf", overflow, 0);
    vec_in = mkvec(13, 14, 15, 16);
    tick();
    valid_in = 1'b0;
    chk("ov.v4.level", fifo_level, 2);
    chk("ov.v4.ovf", overflow, 1);
    oif.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      expect_elem("ov.drain", i + 1, ((i % 4) == 3) ? 1 : 0, 0);
    end
    expect_idle("ov.end");
    chk("ov.sticky", overflow, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("ov.clear", overflow, 0);

    // Drop and clear_err on the same edge: the drop wins
    oif.out_ready = 1'b0;
    valid_in = 1'b1;
    vec_in = mkvec(1, 2, 3, 4);
    tick();
    vec_in = mkvec(5, 6, 7, 8);
    tick();
    vec_in = mkvec(9, 10, 11, 12);
    tick();
    vec_in = mkvec(13, 14, 15, 16);
    clear_err = 1'b1;
    tick();
    valid_in = 1'b0;
    clear_err = 1'b0;
    chk("clrdrop.ovf", overflow, 1);
    chk("clrdrop.level", fifo_level, 2);
    rst_n = 1'b0;
    #1;
    chk("clrdrop.rst.valid", oif.out_valid, 0);
    chk("clrdrop.rst.level", fifo_level, 0);
    chk("clrdrop.rst.ovf", overflow, 0);
    rst_n = 1'b1;
    oif.out_ready = 1'b1;
    tick();
    expect_idle("clrdrop.end");

    // valid_in without commit is ignored
    valid_in = 1'b1;
    commit = 1'b0;
    vec_in = mkvec(7, 7, 7, 7);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_idle("nocommit");
    end
    valid_in = 1'b0;
    commit = 1'b1;

    // Reset mid-SEND at idx 2 with one vector buffered
    shift_amt = 5'd2;
    valid_in = 1'b1;
    vec_in = mkvec(100, -100, 255, -3);
    tick();
    vec_in = mkvec(-98, 2, -2, 6);
    tick();
    valid_in = 1'b0;
    expect_elem("mrst.e0", 25, 0, 0);
    expect_elem("mrst.e1", -25, 0, 0);
    chk("mrst.idx2.data", oif.out_data, 64);
    chk("mrst.idx2.level", fifo_level, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst.async.valid", oif.out_valid, 0);
    chk("mrst.async.level", fifo_level, 0);
    chk("mrst.async.data", oif.out_data, 0);
    chk("mrst.async.last", oif.out_last, 0);
    rst_n = 1'b1;
    tick();
    expect_idle("mrst.post");
    shift_amt = 5'd0;
    vec_in = mkvec(1000, -1000, 127, -128);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    expect_elem("mrst.new.e0", 127, 0, 1);
    expect_elem("mrst.new.e1", -128, 0, 1);
    expect_elem("mrst.new.e2", 127, 0, 0);
    expect_elem("mrst.new.e3", -128, 1, 0);
    expect_idle("mrst.end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
